// File: rtl/fphub_adder_pipe.sv
// Three-stage pipelined HUB floating-point adder/subtractor with a valid/ready handshake.
// Defining FPHUB_ADD_FLAGS_EN adds a registered flags output {overflow, underflow, zero}.
module fphub_adder_pipe #(
  parameter int M = 24,
  parameter int E = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           op_sub,
  input  logic [M+E-1:0] X,
  input  logic [M+E-1:0] Y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M+E-1:0] Z
`ifdef FPHUB_ADD_FLAGS_EN
  ,
  output logic [2:0]     flags
`endif
);

  localparam int W       = M + 4;
  localparam int SHW     = $clog2(W);
  localparam int EXP_MAX = (1 << E) - 1;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic           x_sign, y_sign, sub_eff, x_inf, y_inf, x_zero, y_zero, x_ge;
  logic [E-1:0]   x_exp, y_exp, a_exp, b_exp, d;
  logic [M-2:0]   x_frac, y_frac, a_frac, b_frac;
  logic           a_sign;
  logic [SHW-1:0] shift_n;
  logic           special_n;
  logic [M+E-1:0] spec_z_n;

  assign x_sign  = X[M+E-1];
  assign y_sign  = Y[M+E-1] ^ op_sub;
  assign sub_eff = x_sign ^ y_sign;
  assign x_exp   = X[M+E-2:M-1];
  assign y_exp   = Y[M+E-2:M-1];
  assign x_frac  = X[M-2:0];
  assign y_frac  = Y[M-2:0];
  assign x_inf   = &x_exp;
  assign y_inf   = &y_exp;
  assign x_zero  = (x_exp == '0);
  assign y_zero  = (y_exp == '0);
  assign x_ge    = (X[M+E-2:0] >= Y[M+E-2:0]);

  assign a_sign  = x_ge ? x_sign : y_sign;
  assign a_exp   = x_ge ? x_exp  : y_exp;
  assign a_frac  = x_ge ? x_frac : y_frac;
  assign b_exp   = x_ge ? y_exp  : x_exp;
  assign b_frac  = x_ge ? y_frac : x_frac;
  assign d       = a_exp - b_exp;
  assign shift_n = (32'(d) > 32'(M + 3)) ? SHW'(M + 3) : SHW'(d);

  // Infinities and zero operands bypass the arithmetic and ride down the pipe as a finished result
  always_comb begin
    spec_z_n  = '0;
    special_n = 1'b1;
    if (x_inf && y_inf)
      spec_z_n = sub_eff ? {1'b0, {E{1'b1}}, {(M-1){1'b1}}} : {x_sign, {E{1'b1}}, {(M-1){1'b0}}};
    else if (x_inf)
      spec_z_n = {x_sign, {E{1'b1}}, {(M-1){1'b0}}};
    else if (y_inf)
      spec_z_n = {y_sign, {E{1'b1}}, {(M-1){1'b0}}};
    else if (x_zero)
      spec_z_n = {y_sign, Y[M+E-2:0]};
    else if (y_zero)
      spec_z_n = X;
    else
      special_n = 1'b0;
  end

  logic           s1_valid, s1_special, s1_sign, s1_sub;
  logic [M+E-1:0] s1_spec_z;
  logic [E-1:0]   s1_exp;
  logic [M-2:0]   s1_fa, s1_fb;
  logic [SHW-1:0] s1_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_special <= 1'b0;
      s1_spec_z  <= '0;
      s1_sign    <= 1'b0;
      s1_sub     <= 1'b0;
      s1_exp     <= '0;
      s1_fa      <= '0;
      s1_fb      <= '0;
      s1_shift   <= '0;
    end else if (adv) begin
      s1_valid   <= in_valid;
      s1_special <= special_n;
      s1_spec_z  <= spec_z_n;
      s1_sign    <= a_sign;
      s1_sub     <= sub_eff;
      s1_exp     <= a_exp;
      s1_fa      <= a_frac;
      s1_fb      <= b_frac;
      s1_shift   <= shift_n;
    end
  end

  // Significand is {1, fraction, ILSB} plus three guard bits; shifted-out bits are simply lost
  logic [W-1:0] sig_a, sig_b;
  logic [W:0]   sum_n;
  assign sig_a = {1'b1, s1_fa, 1'b1, 3'b000};
  assign sig_b = {1'b1, s1_fb, 1'b1, 3'b000} >> s1_shift;
  assign sum_n = s1_sub ? ({1'b0, sig_a} - {1'b0, sig_b}) : ({1'b0, sig_a} + {1'b0, sig_b});

  logic           s2_valid, s2_special, s2_sign;
  logic [M+E-1:0] s2_spec_z;
  logic [E-1:0]   s2_exp;
  logic [W:0]     s2_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_special <= 1'b0;
      s2_spec_z  <= '0;
      s2_sign    <= 1'b0;
      s2_exp     <= '0;
      s2_sum     <= '0;
    end else if (adv) begin
      s2_valid   <= s1_valid;
      s2_special <= s1_special;
      s2_spec_z  <= s1_spec_z;
      s2_sign    <= s1_sign;
      s2_exp     <= s1_exp;
      s2_sum     <= sum_n;
    end
  end

  function automatic logic [SHW-1:0] lzc(input logic [W-1:0] v);
    lzc = '0;
    for (int i = 0; i < W; i++)
      if (v[i]) lzc = SHW'(W - 1 - i);
  endfunction

  logic [SHW-1:0]     lz;
  logic [W-1:0]       norm;
  logic signed [31:0] exp_n;
  logic               is_zero, ovf_n, unf_n;
  logic [M+E-1:0]     z_n;
  logic               unused_norm_bits;

  // Normalise so the leading one sits at bit W-1, then truncate below the stored fraction
  always_comb begin
    lz      = lzc(s2_sum[W-1:0]);
    norm    = s2_sum[W-1:0] << lz;
    exp_n   = $signed(32'(s2_exp)) - $signed(32'(lz));
    if (s2_sum[W]) begin
      norm  = s2_sum[W:1];
      exp_n = $signed(32'(s2_exp)) + 1;
    end
    is_zero = (s2_sum == '0);
    ovf_n   = !s2_special && !is_zero && (exp_n >= EXP_MAX);
    unf_n   = !s2_special && !is_zero && (exp_n <= 0);
    z_n     = {s2_sign, exp_n[E-1:0], norm[W-2 -: M-1]};
    if (s2_special)
      z_n = s2_spec_z;
    else if (is_zero || unf_n)
      z_n = '0;
    else if (ovf_n)
      z_n = {s2_sign, {E{1'b1}}, {(M-1){1'b0}}};
  end

  assign unused_norm_bits = ^{norm[W-1], norm[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Z         <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      Z         <= z_n;
    end
  end

`ifdef FPHUB_ADD_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      flags <= 3'b000;
    else if (adv)
      flags <= {ovf_n, unf_n, (z_n[M+E-2:M-1] == '0)};
  end
`endif

endmodule

// File: tb/tb_fphub_adder_pipe.sv
// Scoreboard bench for fphub_adder_pipe: randomized operands checked against an arithmetic model.
module tb_fphub_adder_pipe;

  localparam int M = 24;
  localparam int E = 8;
  localparam int N = M + E;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         op_sub = 1'b0;
  logic         out_ready = 1'b1;
  logic [N-1:0] X = '0;
  logic [N-1:0] Y = '0;
  logic         in_ready, out_valid;
  logic [N-1:0] Z;
`ifdef FPHUB_ADD_FLAGS_EN
  logic [2:0]   flags;
`endif

  fphub_adder_pipe #(.M(M), .E(E)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z)
`ifdef FPHUB_ADD_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [31:0] z;
    logic [2:0]  fl;
    int          acc;
    bit          chk_lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rnd_bp = 0;
  bit   chk_lat_now = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: HUB add on integer significands, normalised by locating the leading one
  function automatic void ref_add(input logic [31:0] x, input logic [31:0] y, input logic sub,
                                  output logic [31:0] z, output logic [2:0] fl);
    logic   sx, sy, sa, sb;
    int     ex, ey, ea, eb, sh, p, e;
    longint fx, fy, fa, fb, ma, mb, r, frac;
    sx = x[31];
    sy = y[31] ^ sub;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    fx = longint'(x[22:0]);
    fy = longint'(y[22:0]);
    fl = 3'b000;
    z  = '0;
    if (ex == 255 && ey == 255)
      z = (sx != sy) ? 32'h7FFF_FFFF : {sx, 8'hFF, 23'd0};
    else if (ex == 255)
      z = {sx, 8'hFF, 23'd0};
    else if (ey == 255)
      z = {sy, 8'hFF, 23'd0};
    else if (ex == 0)
      z = {sy, y[30:0]};
    else if (ey == 0)
      z = x;
    else begin
      if (x[30:0] >= y[30:0]) begin
        sa = sx; ea = ex; fa = fx; sb = sy; eb = ey; fb = fy;
      end else begin
        sa = sy; ea = ey; fa = fy; sb = sx; eb = ex; fb = fx;
      end
      sh = ea - eb;
      if (sh > M + 3) sh = M + 3;
      ma = (longint'('h80_0000) + fa) * 16 + 8;
      mb = ((longint'('h80_0000) + fb) * 16 + 8) >> sh;
      r  = (sa == sb) ? ma + mb : ma - mb;
      if (r != 0) begin
        p = 0;
        for (int i = 0; i < 40; i++)
          if (((r >> i) & 1) != 0) p = i;
        e = ea + p - (M + 3);
        if (e >= 255) begin
          z = {sa, 8'hFF, 23'd0};
          fl[2] = 1'b1;
        end else if (e <= 0) begin
          z = '0;
          fl[1] = 1'b1;
        end else begin
          frac = (p >= 23) ? (r >> (p - 23)) : (r << (23 - p));
          z = {sa, 8'(e), 23'(frac)};
        end
      end
    end
    fl[0] = (z[30:23] == 8'd0);
  endfunction

  // Drive one operation at posedge+1 and wait (bounded) for the handshake; expected value queued at acceptance
  task automatic apply_stimulus(input logic [31:0] x, input logic [31:0] y, input logic sub,
                                input logic [31:0] ez, input logic [2:0] efl);
    bit   ok;
    exp_t e;
    ok = 0;
    in_valid = 1'b1;
    X = x;
    Y = y;
    op_sub = sub;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
      if (rnd_bp) out_ready = ($urandom_range(0, 1) == 1);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
    end else begin
      e.z = ez;
      e.fl = efl;
      e.acc = cycle;
      e.chk_lat = chk_lat_now;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic apply_ref(input logic [31:0] x, input logic [31:0] y, input logic sub);
    logic [31:0] z;
    logic [2:0]  fl;
    ref_add(x, y, sub, z, fl);
    apply_stimulus(x, y, sub, z, fl);
  endtask

  function automatic logic [7:0] rnd_exp(input int base);
    int k, e;
    k = int'($urandom_range(0, 19));
    if (k == 0) return 8'd0;
    if (k == 1) return 8'hFF;
    if (k < 12) e = base + int'($urandom_range(0, 6)) - 3;
    else        e = int'($urandom_range(1, 254));
    if (e < 1)   e = 1;
    if (e > 254) e = 254;
    return 8'(e);
  endfunction

  // Monitor: pops the scoreboard on each output transfer and checks stability while stalled
  initial begin
    exp_t        e;
    bit          held;
    logic [31:0] held_z;
    held = 0;
    held_z = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 0;
      end else begin
        if (held) begin
          check_output("stall_out_valid", 32'(out_valid), 32'd1);
          check_output("stall_z_stable", Z, held_z);
        end
        held = out_valid && !out_ready;
        held_z = Z;
        if (out_valid && !out_ready)
          check_output("stall_in_ready", 32'(in_ready), 32'd0);
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL unexpected_output: got Z=%h, expected no output", Z);
          end else begin
            e = sb_q.pop_front();
            check_output("z", Z, e.z);
`ifdef FPHUB_ADD_FLAGS_EN
            check_output("flags", 32'(flags), 32'(e.fl));
`endif
            if (e.chk_lat) check_output("latency", 32'(cycle - e.acc), 32'd3);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] x, y;
    int          base;
    $display("[TB] start");
    #3;
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_z", Z, 32'd0);
    check_output("reset_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    chk_lat_now = 1;
    apply_stimulus(32'h4040_0000, 32'h40A0_0000, 1'b0, 32'h4100_0000, 3'b000);
    apply_stimulus(32'h4040_0000, 32'h40A0_0000, 1'b1, 32'hC000_0000, 3'b000);
    apply_stimulus(32'h4040_0000, 32'h4040_0000, 1'b1, 32'h0000_0000, 3'b001);
    apply_stimulus(32'h0000_0000, 32'h40A0_0000, 1'b0, 32'h40A0_0000, 3'b000);
    apply_stimulus(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b100);
    apply_stimulus(32'h7F80_0000, 32'h4040_0000, 1'b0, 32'h7F80_0000, 3'b000);
    apply_stimulus(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FFF_FFFF, 3'b000);
    apply_ref(32'h0080_0000, 32'h00C0_0000, 1'b1);
    apply_ref(32'h4040_0000, 32'h0000_0000, 1'b1);
    apply_ref(32'h4B80_0000, 32'h3F80_0000, 1'b1);
    chk_lat_now = 0;
    repeat (6) @(posedge clk);
    #1;

    // Back-pressure: consumer stalls from the first result; fourth op must wait for space
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          apply_ref(32'h3F80_0000 + 32'(i << 20), 32'h4000_0000 + 32'(i << 19), 1'b0);
      end
      begin
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_output("bp_in_ready_low", 32'(in_ready), 32'd0);
        check_output("bp_out_valid_high", 32'(out_valid), 32'd1);
        check_output("bp_held_count", 32'(sb_q.size()), 32'd3);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // Randomized traffic with a randomly stalling consumer
    rnd_bp = 1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 4))
        0:       base = 1;
        1:       base = 254;
        2:       base = 127;
        default: base = int'($urandom_range(1, 254));
      endcase
      x = {1'($urandom), rnd_exp(base), 23'($urandom)};
      y = {1'($urandom), rnd_exp(base), 23'($urandom)};
      if ($urandom_range(0, 3) == 0) y[22:0] = x[22:0];
      apply_ref(x, y, 1'($urandom));
    end
    rnd_bp = 0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Reset with two operations in flight: both must vanish
    apply_ref(32'h4040_0000, 32'h40A0_0000, 1'b0);
    apply_ref(32'h4120_0000, 32'h3F80_0000, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_out_valid", 32'(out_valid), 32'd0);
    check_output("async_reset_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output("post_reset_idle", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    apply_ref(32'h4040_0000, 32'h40A0_0000, 1'b1);

    for (int t = 0; t < 200 && sb_q.size() != 0; t++) @(posedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fphub_adder_pipe.md
Name: fphub_adder_pipe

Overview:
- Pipelined, parametrised HUB floating-point adder/subtractor. It is the clocked successor to the combinational FPHUB adder in the arithmetic datapath.
- Accepts one operand pair per cycle over a valid/ready handshake and returns Z = X ± Y after a fixed 3-stage latency.
- Round-to-nearest comes from plain truncation, as the HUB format requires.
- Sits between the operand-issue logic and the result writeback.

Parameters:
- M, 24, significand width including the implicit leading 1. Stored fraction is M-1 bits; the implicit LSB (ILSB) of 1 is appended internally.
- E, 8, exponent width; bias = 2^(E-1)-1.

Ports:
- clk  in  1  clock, all state on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  adder can accept
- op_sub  in  1  0: Z=X+Y, 1: Z=X-Y
- X  in  M+E  operand: sign [M+E-1], exponent [M+E-2:M-1], fraction [M-2:0]
- Y  in  M+E  operand, same format
- out_valid  out  1  Z valid
- out_ready  in  1  consumer accepts Z
- Z  out  M+E  result, same format

Behaviour:
- Reset: rst_n low asynchronously clears all stage valid bits. out_valid=0, Z=0. in_ready=1 once out_valid is 0.
- Reset mid-operation discards in-flight operations; nothing is emitted after release.
- Global advance: adv = !out_valid | out_ready; in_ready = adv.
- An input transfers when in_valid & in_ready.
- When adv=0, every stage holds its data and valid.
- Bubbles propagate as invalid stages; no bubble collapsing.
- Latency: operation accepted in cycle n appears on Z with out_valid=1 in cycle n+3, given no stall. Throughput is 1/cycle. Results stay in order.
- Z and out_valid are stable while out_valid=1 and out_ready=0.
- S1: form effective Y sign (sign_Y ^ op_sub).
  - Swap so the larger magnitude is A; compare {exponent, fraction}. Equal magnitudes keep X as A.
  - d = expA - expB.
  - Zero/special classification.
- S2: significands {1, fraction, ILSB} extended by 3 guard bits.
  - B shifted right by min(d, M+3).
  - Bits shifted out are dropped; there is no sticky bit.
  - Add if signs are equal, otherwise A-B (never negative).
- S3: leading-one detect and normalise.
  - A carry-out shifts right 1, with exponent+1. Otherwise shift left by the LZC, with exponent-LZC.
  - Truncate to M-1 fraction bits; the ILSB is implicit.
  - Result sign = sign of A.
- Zero: exponent field 0 means zero, whatever the fraction. No subnormals.
  - Zero ± Y returns Y unchanged, sign applied.
  - Exact cancellation returns +0 (all zeros).
- Exponent all-ones means infinity; the fraction is ignored.
  - inf ± finite = that inf.
  - inf - inf = +inf with fraction all-ones (NaN pattern).
- Overflow: result exponent ≥ 2^E-1 saturates to ±inf (exponent all-ones, fraction 0).
- Underflow: result exponent ≤ 0 flushes to +0.

Optional Feature:
- Macro FPHUB_ADD_FLAGS_EN.
- When defined, adds output port flags [2:0] = {overflow, underflow, zero}.
  - Flags are registered in S3 and aligned with Z.
  - flags reset to 0 and hold under stall like Z.
  - zero is set for any zero result, including exact cancellation and zero operands.
- When not defined, the port and its logic are absent; Z behaviour is identical.

Test Plan:
- M=24, E=8 for all cases; out_ready=1 unless stated.
- Add: X=0x40400000, Y=0x40A00000, op_sub=0 -> Z=0x41000000 exactly 3 cycles after acceptance.
- Subtract with swap: X=0x40400000, Y=0x40A00000, op_sub=1 -> Z=0xC0000000.
- Cancellation: X=0x40400000, Y=0x40400000, op_sub=1 -> Z=0x00000000, flags=3'b001. Zero operand: X=0x00000000, Y=0x40A00000 add -> Z=0x40A00000.
- Overflow: X=Y=0x7F7FFFFF add -> Z=0x7F800000, flags=3'b100. X=0x7F800000, Y=0x40400000 -> Z=0x7F800000.
- Back-pressure:
  - Issue 4 back-to-back adds while out_ready=0 from the first result onward.
  - in_ready drops once 3 results are held; Z stays stable.
  - Raising out_ready drains all 4 in order with no loss or duplication.
- Async reset: assert rst_n low mid-stream with 2 ops in flight -> out_valid=0 immediately; no stale result after release.
